apipe_sync_sink: RTL and testbench

- Downstream consumer of the 8-bit asynchronous (self-timed) pipeline.
- Accepts tokens over a 4-phase bundled-data req/ack handshake and synchronizes them into the single clock domain.
- Buffers tokens in a small first-word-fall-through FIFO and presents them as a valid/ready stream to clocked logic.
- Backpressure works by withholding ack, so no token is ever dropped.

---
 rtl/apipe_sync_sink_pkg.sv | 14 +
 rtl/apipe_sync_sink_sync_ff.sv | 31 +++
 rtl/apipe_sync_sink.sv | 110 +++++++++++
 tb/tb_apipe_sync_sink.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apipe_sync_sink_pkg.sv
// Shared definitions for the async-pipeline sink: FSM state encoding and
// default geometry used by apipe_sync_sink and its synchronizer.
package apipe_sync_sink_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    localparam int DEF_DW          = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/apipe_sync_sink_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; the first flop may
// go metastable, the remaining STAGES-1 flops give it time to resolve.
module apipe_sync_ff
    import apipe_sync_sink_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], i_d};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign o_q = chain_q[STAGES-1];

endmodule

// File: rtl/apipe_sync_sink.sv
// Clocked sink for a 4-phase bundled-data asynchronous pipeline: synchronizes
// req, captures tokens into a first-word-fall-through FIFO, streams them out.
module apipe_sync_sink
    import apipe_sync_sink_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req,
    output logic                       o_ack,
    input  logic [DW-1:0]              i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DW-1:0]              o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    // Handshakes:
    //  - Async side is 4-phase: req rises with i_data settled; ack rises once the
    //    token is stored; req falls; ack falls. A full FIFO simply delays the
    //    ack rise, so the producer stalls and nothing is dropped.
    //  - Clocked side is valid/ready: a transfer happens on every edge where
    //    o_valid & i_ready; o_data holds the FIFO head and is stable until popped.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          req_s;
    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push;
    logic          pop;

    apipe_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_req),
        .o_q   (req_s)
    );

    always_comb begin
        // Fullness looks at the registered count only: a pop on the same edge
        // frees a slot that can be used on the following edge at the earliest.
        push = (state_q == ST_IDLE) && req_s && (count_q != FULL_CNT);
        pop  = (count_q != '0) && i_ready;

        state_d = state_q;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_ack   = ack_q;
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: tb/tb_apipe_sync_sink.sv
// Bench for apipe_sync_sink: a behavioural 4-phase producer and a token-queue
// model of the FIFO contents, plus directed latency and backpressure steps.
module tb_apipe_sync_sink;

    localparam int DW          = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic          i_clk;
    logic          i_rst;
    logic          i_req;
    logic          o_ack;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [$clog2(DEPTH):0] o_count;

    apipe_sync_sink #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .o_ack   (o_ack),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Tokens the DUT currently holds, oldest first, and tokens still to send.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] pend_tok;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  rise_edge = 0;
    int  fall_edge = 0;
    int  n_pops = 0;
    int  ready_mode = 0;
    bit  auto_prod = 0;
    bit  cnt_le1 = 0;
    bit  saw_full = 0;
    logic req_prev = 1'b0;
    logic ack_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic raise_req(input logic [DW-1:0] tok);
        i_req    = 1'b1;
        i_data   = tok;
        pend_tok = tok;
    endtask

    // One clock: apply the pop decided by the current inputs, advance, update
    // the token model from observed ack edges, compare, then drive next inputs.
    task automatic cycle();
        if (o_valid && i_ready && exp_q.size() > 0) begin
            check("pop_data", o_data, exp_q[0]);
            void'(exp_q.pop_front());
            n_pops++;
        end
        if (i_req && !req_prev) begin
            rise_edge = cyc;
            saw_full  = 0;
        end
        if (!i_req && req_prev) fall_edge = cyc;
        req_prev = i_req;

        @(posedge i_clk);
        #1;
        cyc++;

        if (o_ack && !ack_prev) begin
            exp_q.push_back(pend_tok);
            if (!saw_full) check("req_to_ack_rise", cyc - rise_edge, LAT);
        end
        if (!o_ack && ack_prev) check("req_to_ack_fall", cyc - fall_edge, LAT);
        ack_prev = o_ack;
        if (i_req && !o_ack && exp_q.size() == DEPTH) saw_full = 1;

        check("count", o_count, exp_q.size());
        check("valid", o_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("head", o_data, exp_q[0]);
        if (cnt_le1) check("stream_count_le1", o_count <= 1, 1);

        if (auto_prod) begin
            if (i_req && o_ack) begin
                i_req  = 1'b0;
                i_data = DW'($urandom);
            end else if (!i_req && !o_ack && src_q.size() > 0) begin
                raise_req(src_q.pop_front());
            end
        end
        if (ready_mode == 1) i_ready = ~i_ready;
        else if (ready_mode == 2) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_done(input string tag, input bit drain, input int budget);
        int k = 0;
        bit done = 0;
        while (k < budget) begin
            done = (src_q.size() == 0) && !i_req && !o_ack && (!drain || exp_q.size() == 0);
            if (done) break;
            cycle();
            k++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_req   = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        pend_tok = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ack", o_ack, 0);
        check("rst_valid", o_valid, 0);
        check("rst_count", o_count, 0);
        i_rst = 1'b0;

        // Single token with the consumer stalled.
        raise_req(8'h5A);
        cycle();
        check("single_ack_e1", o_ack, 0);
        cycle();
        check("single_ack_e2", o_ack, 0);
        cycle();
        check("single_ack_e3", o_ack, 1);
        check("single_valid", o_valid, 1);
        check("single_data", o_data, 8'h5A);
        check("single_count", o_count, 1);
        i_req = 1'b0;
        cycle();
        cycle();
        check("single_ackfall_e2", o_ack, 1);
        cycle();
        check("single_ackfall_e3", o_ack, 0);
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
        check("single_popped", o_valid, 0);

        // Back-to-back stream with an always-ready consumer.
        n_pops = 0;
        for (int i = 0; i < 8; i++) src_q.push_back(DW'(i));
        i_ready   = 1'b1;
        auto_prod = 1;
        cnt_le1   = 1;
        wait_done("stream_timeout", 1, 200);
        cnt_le1 = 0;
        check("stream_pops", n_pops, 8);

        // Backpressure: four tokens fill the FIFO, the fifth stalls.
        i_ready = 1'b0;
        for (int i = 1; i <= 5; i++) src_q.push_back(DW'(i));
        repeat (50) cycle();
        check("bp_count_full", o_count, DEPTH);
        check("bp_ack_stalled", o_ack, 0);
        check("bp_head", o_data, 8'h01);
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
        check("bp_no_push_on_pop_edge", o_ack, 0);
        check("bp_count_after_pop", o_count, 3);
        cycle();
        check("bp_fifth_captured", o_ack, 1);
        check("bp_count_refill", o_count, DEPTH);
        check("bp_head_after", o_data, 8'h02);
        i_ready = 1'b1;
        wait_done("bp_drain_timeout", 1, 200);

        // Push and pop on the same edge at occupancy 2.
        i_ready = 1'b0;
        src_q.push_back(8'h10);
        src_q.push_back(8'h11);
        wait_done("pp_fill_timeout", 0, 100);
        check("pp_count_pre", o_count, 2);
        auto_prod = 0;
        raise_req(8'h12);
        cycle();
        cycle();
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
        check("pp_ack", o_ack, 1);
        check("pp_count", o_count, 2);
        check("pp_head", o_data, 8'h11);
        auto_prod = 1;
        i_ready   = 1'b1;
        wait_done("pp_drain_timeout", 1, 100);

        // Pointer wrap with a toggling consumer.
        for (int i = 0; i < 10; i++) src_q.push_back(8'hA0 + DW'(i));
        ready_mode = 1;
        wait_done("wrap_timeout", 1, 400);
        check("wrap_count_end", o_count, 0);

        // Random tokens against a random consumer.
        for (int i = 0; i < 24; i++) src_q.push_back(DW'($urandom_range(0, 255)));
        ready_mode = 2;
        wait_done("rand_timeout", 1, 1000);
        ready_mode = 0;

        // Reset in the middle of a handshake with three tokens held.
        i_ready = 1'b0;
        src_q.push_back(8'hC0);
        src_q.push_back(8'hC1);
        wait_done("mid_fill_timeout", 0, 100);
        auto_prod = 0;
        raise_req(8'hC2);
        for (int k = 0; k < 10 && !o_ack; k++) cycle();
        check("mid_ack_high", o_ack, 1);
        check("mid_count", o_count, 3);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_ack", o_ack, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_count", o_count, 0);
        i_req = 1'b0;
        exp_q.delete();
        req_prev = 1'b0;
        ack_prev = 1'b0;
        #2;
        i_rst = 1'b0;
        repeat (10) cycle();
        check("post_rst_ack", o_ack, 0);
        check("post_rst_count", o_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
